// File: rtl/dec_pkg.sv
// Shared types and widths for the 2-to-4 decoder with timed hold.
package dec_pkg;

  localparam int unsigned CODE_W   = 2;
  localparam int unsigned ONEHOT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HOLD,
    ST_GAP
  } dec_state_t;

endpackage

// File: rtl/dec2x4_comb.sv
// Gate-level 2-to-4 one-hot decoder; the mirror of the 4x2 gate-level encoder.
//   code_i   : binary code 0..3
//   onehot_o : onehot_o[code_i] = 1, all other bits 0
module dec2x4_comb
  import dec_pkg::*;
(
  input  logic [CODE_W-1:0]   code_i,
  output logic [ONEHOT_W-1:0] onehot_o
);

  logic c0_n;
  logic c1_n;

  not u_not0 (c0_n, code_i[0]);
  not u_not1 (c1_n, code_i[1]);

  and u_and0 (onehot_o[0], c1_n,      c0_n);
  and u_and1 (onehot_o[1], c1_n,      code_i[0]);
  and u_and2 (onehot_o[2], code_i[1], c0_n);
  and u_and3 (onehot_o[3], code_i[1], code_i[0]);

endmodule

// File: rtl/dec2x4_hold.sv
// Registered 2-to-4 one-hot decoder with valid/ready intake, a timed output
// hold and an optional idle gap before the next code is accepted.
//   clk, rst_n : clock, synchronous active-low reset
//   en         : enables acceptance (only looked at in IDLE)
//   in_valid   : code is valid this cycle
//   code       : 2-bit code to decode
//   in_ready   : decoder can accept a code this cycle
//   out        : one-hot decoded value, 0 when idle
//   out_valid  : out carries a decoded value
//   busy       : symbol in flight (HOLD or GAP)
//   dec_count  : accepted codes, modulo 2^CNT_W
module dec2x4_hold
  import dec_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 4,
  parameter int unsigned GAP_CYCLES  = 1,
  parameter int unsigned CNT_W       = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic                in_valid,
  input  logic [CODE_W-1:0]   code,
  output logic                in_ready,
  output logic [ONEHOT_W-1:0] out,
  output logic                out_valid,
  output logic                busy,
  output logic [CNT_W-1:0]    dec_count
);

  // Down-counters only need to hold N-1; keep at least one bit.
  localparam int unsigned HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int unsigned GAP_W  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  dec_state_t          state_q, state_d;
  logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
  logic [GAP_W-1:0]    gap_cnt_q, gap_cnt_d;
  logic [ONEHOT_W-1:0] out_q, out_d;
  logic                out_valid_q, out_valid_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ONEHOT_W-1:0] onehot;
  logic                accept;

  dec2x4_comb u_dec (
    .code_i   (code),
    .onehot_o (onehot)
  );

  // Ready is a function of registered state and the level inputs only.
  assign in_ready  = rst_n & en & (state_q == ST_IDLE);
  assign accept    = in_valid & in_ready;
  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign busy      = (state_q != ST_IDLE);
  assign dec_count = cnt_q;

  // Next-state and next-output logic.
  always_comb begin
    state_d     = state_q;
    hold_cnt_d  = hold_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    out_d       = out_q;
    out_valid_d = out_valid_q;
    cnt_d       = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d     = ST_HOLD;
          hold_cnt_d  = HOLD_W'(HOLD_CYCLES - 1);
          out_d       = onehot;
          out_valid_d = 1'b1;
          cnt_d       = cnt_q + CNT_W'(1);
        end
      end
      ST_HOLD: begin
        if (hold_cnt_q == '0) begin
          out_d       = '0;
          out_valid_d = 1'b0;
          if (GAP_CYCLES > 0) begin
            state_d   = ST_GAP;
            gap_cnt_d = GAP_W'(GAP_CYCLES - 1);
          end else begin
            state_d   = ST_IDLE;
          end
        end else begin
          hold_cnt_d = hold_cnt_q - HOLD_W'(1);
        end
      end
      ST_GAP: begin
        if (gap_cnt_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q - GAP_W'(1);
        end
      end
      default: begin
        state_d     = ST_IDLE;
        out_d       = '0;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // State register; reset aborts any symbol in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      hold_cnt_q  <= '0;
      gap_cnt_q   <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      hold_cnt_q  <= hold_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      cnt_q       <= cnt_d;
    end
  end

endmodule

// File: tb/tb_dec2x4_hold.sv
// Self-checking bench: two decoder instances (default timing and a short
// HOLD=1/GAP=0/CNT_W=2 build) share the same stimulus and are compared every
// cycle against a timeline model built from accept times.
module tb_dec2x4_hold;

  logic       clk = 1'b0;
  logic       rst_n, en, in_valid;
  logic [1:0] code;

  logic       rdy0, rdy1, ov0, ov1, busy0, busy1;
  logic [3:0] out0, out1;
  logic [7:0] cnt0;
  logic [1:0] cnt1;

  always #5 clk = ~clk;

  dec2x4_hold #(.HOLD_CYCLES(4), .GAP_CYCLES(1), .CNT_W(8)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid), .code(code),
    .in_ready(rdy0), .out(out0), .out_valid(ov0), .busy(busy0), .dec_count(cnt0)
  );

  dec2x4_hold #(.HOLD_CYCLES(1), .GAP_CYCLES(0), .CNT_W(2)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid), .code(code),
    .in_ready(rdy1), .out(out1), .out_valid(ov1), .busy(busy1), .dec_count(cnt1)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Model parameters and state per instance.
  int     hc[2]    = '{4, 1};
  int     gc[2]    = '{1, 0};
  int     cmask[2] = '{255, 3};
  longint acc[2]   = '{-1000, -1000};
  int     mcode[2] = '{0, 0};
  int     mcnt[2]  = '{0, 0};
  longint cyc      = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  // Symbol timeline: after the accept edge, H cycles of one-hot then G zero cycles.
  function automatic bit m_busy(int i);
    longint s = cyc - acc[i];
    return (s >= 0) && (s < hc[i] + gc[i]);
  endfunction

  function automatic int m_out(int i);
    longint s = cyc - acc[i];
    return ((s >= 0) && (s < hc[i])) ? (1 << mcode[i]) : 0;
  endfunction

  function automatic int enc4(logic [3:0] v);
    int r = 0;
    for (int b = 0; b < 4; b++) if (v[b]) r = b;
    return r;
  endfunction

  // One clock: check ready, advance the model on the edge, check outputs.
  task automatic step();
    bit exp_rdy[2];
    bit acc_now[2];
    int o, ov, bz, cn;
    #1;
    for (int i = 0; i < 2; i++) begin
      exp_rdy[i] = rst_n && en && !m_busy(i);
      acc_now[i] = in_valid && exp_rdy[i];
      check(i == 0 ? "ready0" : "ready1", int'(i == 0 ? rdy0 : rdy1), int'(exp_rdy[i]));
    end
    @(posedge clk);
    cyc++;
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        acc[i]  = -1000;
        mcnt[i] = 0;
      end else if (acc_now[i]) begin
        acc[i]   = cyc;
        mcode[i] = int'(code);
        mcnt[i]++;
      end
    end
    #1;
    for (int i = 0; i < 2; i++) begin
      o  = int'(i == 0 ? out0 : out1);
      ov = int'(i == 0 ? ov0 : ov1);
      bz = int'(i == 0 ? busy0 : busy1);
      cn = (i == 0) ? int'(cnt0) : int'(cnt1);
      check(i == 0 ? "out0" : "out1", o, m_out(i));
      check(i == 0 ? "outv0" : "outv1", ov, int'(m_out(i) != 0));
      check(i == 0 ? "busy0" : "busy1", bz, int'(m_busy(i)));
      check(i == 0 ? "cnt0" : "cnt1", cn, mcnt[i] & cmask[i]);
      if (m_out(i) != 0)
        check(i == 0 ? "enc0" : "enc1", enc4(4'(o)), mcode[i]);
    end
  endtask

  initial begin
    int guard;
    rst_n = 1'b0; en = 1'b1; in_valid = 1'b1; code = 2'd2;
    @(posedge clk);
    #1;
    // Reset with en/in_valid high: nothing accepted.
    step();
    step();
    // First accept on the first edge after release.
    rst_n = 1'b1;
    step();
    check("first_accept", int'(cnt0), 1);

    // Let code 2 run its full hold + gap.
    in_valid = 1'b0;
    for (int k = 0; k < 6; k++) step();

    // Sweep 0..3 with in_valid held; code advances after each dut0 accept.
    in_valid = 1'b1;
    for (int k = 0; k < 30; k++) begin
      code = 2'(mcnt[0]);
      step();
    end

    // en=0 in IDLE blocks; dropped mid-hold lets the hold finish.
    in_valid = 1'b0;
    for (int k = 0; k < 6; k++) step();
    en = 1'b0; in_valid = 1'b1;
    for (int k = 0; k < 8; k++) step();
    en = 1'b1; code = 2'd3;
    step();
    en = 1'b0;
    for (int k = 0; k < 8; k++) step();

    // Reset in the second hold cycle of dut0.
    en = 1'b1; in_valid = 1'b0;
    for (int k = 0; k < 6; k++) step();
    in_valid = 1'b1; code = 2'd1;
    guard = 0;
    while (!busy0 && guard < 20) begin
      step();
      guard++;
    end
    check("busy_wait", int'(busy0), 1);
    in_valid = 1'b0;
    step();
    rst_n = 1'b0;
    step();
    check("rst_mid_out", int'(out0), 0);
    rst_n = 1'b1;

    // Randomized traffic with occasional resets.
    for (int k = 0; k < 1500; k++) begin
      rst_n    = ($urandom_range(0, 79) != 0);
      en       = ($urandom_range(0, 7) != 0);
      in_valid = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 2) == 0) code = 2'($urandom_range(0, 3));
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
